// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants and update-result type for the LIF neuron array
//
// Purpose: default parameter values for lif_array and the packed struct that
//          carries one neuron's next state out of the combinational update.
// Ports:   none (package).

package lif_pkg;

  localparam int LIF_THR_INIT = 100;
  localparam int LIF_THR_MIN  = 8;
  localparam int LIF_THR_MAX  = 240;
  localparam int LIF_UP_SHIFT = 3;
  localparam int LIF_DN_SHIFT = 5;
  localparam int LIF_REFRAC   = 2;

  // The result struct is sized for the widest supported datapath; narrower
  // instances use the low W bits of each field.
  localparam int LIF_MAX_W    = 16;
  localparam int LIF_REFR_W   = 8;

  typedef struct packed {
    logic [LIF_MAX_W-1:0]  v_next;
    logic [LIF_MAX_W-1:0]  thr_next;
    logic [LIF_REFR_W-1:0] refr_next;
    logic                  spike;
    logic [LIF_MAX_W-1:0]  state_out;
  } lif_upd_t;

endpackage

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational single-neuron leaky integrate-and-fire update
//
// Purpose: given one neuron's stored potential, threshold and refractory count
//          plus an input current, compute its next state and the emitted result.
// Ports:
//   v          in   W            stored potential
//   thr        in   W            stored adaptive threshold
//   refr       in   LIF_REFR_W   remaining refractory updates
//   current    in   W            unsigned synaptic current
//   beta       in   8            leak factor, beta/256
//   learn_thr  in   1            enable threshold adaptation
//   upd        out  lif_upd_t    next state, spike flag and output potential

module lif_update
  import lif_pkg::*;
#(
  parameter int W        = 8,
  parameter int THR_MIN  = LIF_THR_MIN,
  parameter int THR_MAX  = LIF_THR_MAX,
  parameter int UP_SHIFT = LIF_UP_SHIFT,
  parameter int DN_SHIFT = LIF_DN_SHIFT,
  parameter int REFRAC   = LIF_REFRAC
) (
  input  logic [W-1:0]          v,
  input  logic [W-1:0]          thr,
  input  logic [LIF_REFR_W-1:0] refr,
  input  logic [W-1:0]          current,
  input  logic [7:0]            beta,
  input  logic                  learn_thr,
  output lif_upd_t              upd
);

  localparam logic [W:0] THR_MIN_V = (W+1)'(THR_MIN);
  localparam logic [W:0] THR_MAX_V = (W+1)'(THR_MAX);

  logic [W+7:0] prod;
  logic [W-1:0] leak;
  logic [W:0]   sum_wide;
  logic [W-1:0] sum_sat;
  logic [W:0]   thr_w;
  logic [W:0]   thr_up;
  logic [W:0]   thr_dn;

  // Leak keeps the integer part of v*beta/256.
  assign prod     = {8'b0, v} * {{W{1'b0}}, beta};
  assign leak     = W'(prod >> 8);
  assign sum_wide = {1'b0, current} + {1'b0, leak};
  assign sum_sat  = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];

  // One extra bit so the raise cannot wrap before the ceiling clamp.
  assign thr_w  = {1'b0, thr};
  assign thr_up = thr_w + (thr_w >> UP_SHIFT);
  assign thr_dn = thr_w - (thr_w >> DN_SHIFT);

  always_comb begin
    upd = '0;
    upd.thr_next[W-1:0] = thr;
    if (refr != '0) begin
      // Refractory: the current is discarded and the potential held at rest.
      upd.refr_next = refr - 1'b1;
    end else if (sum_sat >= thr) begin
      upd.spike             = 1'b1;
      upd.state_out[W-1:0]  = sum_sat;
      upd.refr_next         = LIF_REFR_W'(REFRAC);
      if (learn_thr) begin
        upd.thr_next[W-1:0] = (thr_up > THR_MAX_V) ? THR_MAX_V[W-1:0] : thr_up[W-1:0];
      end
    end else begin
      upd.state_out[W-1:0]  = sum_sat;
      upd.v_next[W-1:0]     = sum_sat;
      if (learn_thr) begin
        upd.thr_next[W-1:0] = (thr_dn < THR_MIN_V) ? THR_MIN_V[W-1:0] : thr_dn[W-1:0];
      end
    end
  end

endmodule

// File: rtl/lif_array.sv
// rtl/lif_array.sv - time-multiplexed array of N leaky integrate-and-fire neurons
//
// Purpose: holds per-neuron potential, threshold and refractory count; each
//          accepted event does one read-modify-write through lif_update and
//          the result is presented on a registered valid/ready stream.
// Ports:
//   clk         in   1      clock
//   rst         in   1      synchronous reset, active-high
//   beta        in   8      leak factor, beta/256, sampled per event
//   learn_thr   in   1      threshold adaptation enable, sampled per event
//   in_valid    in   1      event valid
//   in_ready    out  1      event accepted when in_valid && in_ready
//   in_idx      in   IDX_W  target neuron
//   in_current  in   W      unsigned input current
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream accepts result
//   out_idx     out  IDX_W  neuron index of result
//   out_spike   out  1      neuron fired
//   out_state   out  W      saturated potential before spike reset

module lif_array
  import lif_pkg::*;
#(
  parameter int N        = 16,
  parameter int IDX_W    = (N > 1) ? $clog2(N) : 1,
  parameter int W        = 8,
  parameter int THR_INIT = LIF_THR_INIT,
  parameter int THR_MIN  = LIF_THR_MIN,
  parameter int THR_MAX  = LIF_THR_MAX,
  parameter int UP_SHIFT = LIF_UP_SHIFT,
  parameter int DN_SHIFT = LIF_DN_SHIFT,
  parameter int REFRAC   = LIF_REFRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       beta,
  input  logic             learn_thr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [W-1:0]     in_current,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_spike,
  output logic [W-1:0]     out_state
);

  localparam logic [IDX_W:0] N_V = (IDX_W+1)'(N);

  logic [W-1:0]          v_mem    [N];
  logic [W-1:0]          thr_mem  [N];
  logic [LIF_REFR_W-1:0] refr_mem [N];

  logic             accept;
  logic             idx_ok;
  logic [IDX_W-1:0] rd_idx;
  lif_upd_t         upd;

  // Single output register with no skid buffer: a new event can only be taken
  // when the register is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign idx_ok   = {1'b0, in_idx} < N_V;
  assign rd_idx   = idx_ok ? in_idx : '0;

  lif_update #(
    .W        (W),
    .THR_MIN  (THR_MIN),
    .THR_MAX  (THR_MAX),
    .UP_SHIFT (UP_SHIFT),
    .DN_SHIFT (DN_SHIFT),
    .REFRAC   (REFRAC)
  ) u_update (
    .v         (v_mem[rd_idx]),
    .thr       (thr_mem[rd_idx]),
    .refr      (refr_mem[rd_idx]),
    .current   (in_current),
    .beta      (beta),
    .learn_thr (learn_thr),
    .upd       (upd)
  );

  if (W < LIF_MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{upd.v_next[LIF_MAX_W-1:W], upd.thr_next[LIF_MAX_W-1:W],
                         upd.state_out[LIF_MAX_W-1:W]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        v_mem[i]    <= '0;
        thr_mem[i]  <= W'(THR_INIT);
        refr_mem[i] <= '0;
      end
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_spike <= 1'b0;
      out_state <= '0;
    end else begin
      if (accept && idx_ok) begin
        v_mem[in_idx]    <= upd.v_next[W-1:0];
        thr_mem[in_idx]  <= upd.thr_next[W-1:0];
        refr_mem[in_idx] <= upd.refr_next;
      end
      if (accept) begin
        // Out-of-range events are swallowed: accepted but produce no result.
        out_valid <= idx_ok;
        if (idx_ok) begin
          out_idx   <= in_idx;
          out_spike <= upd.spike;
          out_state <= upd.state_out[W-1:0];
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// tb/tb_lif_array.sv - self-checking bench for lif_array

module tb_lif_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] beta;
  logic       learn_thr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_idx;
  logic [7:0] in_current;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic       out_spike;
  logic [7:0] out_state;

  logic [7:0] b_beta;
  logic       b_learn_thr;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [3:0] b_in_idx;
  logic [7:0] b_in_current;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [3:0] b_out_idx;
  logic       b_out_spike;
  logic [7:0] b_out_state;

  always #5 clk = ~clk;

  lif_array dut (
    .clk(clk), .rst(rst), .beta(beta), .learn_thr(learn_thr),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_current(in_current),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_spike(out_spike), .out_state(out_state)
  );

  lif_array #(.N(12), .THR_INIT(250), .THR_MAX(255)) dut_b (
    .clk(clk), .rst(rst), .beta(b_beta), .learn_thr(b_learn_thr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx), .in_current(b_in_current),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
    .out_spike(b_out_spike), .out_state(b_out_state)
  );

  typedef struct {
    int idx;
    int spike;
    int state;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   last_acc;

  int mv[16];
  int mthr[16];
  int mrefr[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0;
      mthr[i] = 100;
      mrefr[i] = 0;
    end
  endfunction

  function automatic void model_step(input int idx, input int cur, input int b, input bit lrn,
                                     output int spk, output int st);
    int sum;
    int t;
    spk = 0;
    st  = 0;
    if (mrefr[idx] > 0) begin
      mrefr[idx] = mrefr[idx] - 1;
      mv[idx] = 0;
    end else begin
      sum = cur + (mv[idx] * b) / 256;
      if (sum > 255) sum = 255;
      st = sum;
      if (sum >= mthr[idx]) begin
        spk = 1;
        mv[idx] = 0;
        mrefr[idx] = 2;
        if (lrn) begin
          t = mthr[idx] + mthr[idx] / 8;
          mthr[idx] = (t > 240) ? 240 : t;
        end
      end else begin
        mv[idx] = sum;
        if (lrn) begin
          t = mthr[idx] - mthr[idx] / 32;
          mthr[idx] = (t < 8) ? 8 : t;
        end
      end
    end
  endfunction

  // One clock: observe handshakes at the falling edge, then advance.
  task automatic cycle();
    bit   acc;
    bit   xfer;
    exp_t e;
    int   spk;
    int   st;
    @(negedge clk);
    chk("in_ready", in_ready, !out_valid || out_ready);
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    if (xfer) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_idx", out_idx, e.idx);
        chk("out_spike", out_spike, e.spike);
        chk("out_state", out_state, e.state);
      end
    end
    last_acc = acc;
    if (acc) begin
      model_step(int'(in_idx), int'(in_current), int'(beta), learn_thr, spk, st);
      sb.push_back('{idx: int'(in_idx), spike: spk, state: st});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input int cur);
    in_valid   = 1'b1;
    in_idx     = 4'(idx);
    in_current = 8'(cur);
    last_acc   = 1'b0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20; t++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic bstep(input int idx, input int cur, input int ev, input int eidx,
                       input int espk, input int est);
    b_in_valid   = 1'b1;
    b_in_idx     = 4'(idx);
    b_in_current = 8'(cur);
    @(negedge clk);
    chk("b_in_ready", b_in_ready, 1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    chk("b_out_valid", b_out_valid, ev);
    if (ev != 0) begin
      chk("b_out_idx", b_out_idx, eidx);
      chk("b_out_spike", b_out_spike, espk);
      chk("b_out_state", b_out_state, est);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    beta = 8'd224;
    learn_thr = 1'b0;
    in_valid = 1'b0;
    in_idx = '0;
    in_current = '0;
    out_ready = 1'b1;
    b_beta = 8'd255;
    b_learn_thr = 1'b0;
    b_in_valid = 1'b0;
    b_in_idx = '0;
    b_in_current = '0;
    b_out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_spike", out_spike, 0);
    chk("rst_out_state", out_state, 0);

    // Integrate, fire, refractory, resume (beta=224)
    for (int k = 0; k < 5; k++) send(0, 60);
    drain();

    // Threshold adaptation on neuron 3 (beta=0 isolates the threshold)
    beta = 8'd0;
    learn_thr = 1'b1;
    send(3, 0);
    send(3, 120);
    learn_thr = 1'b0;
    send(3, 0);
    send(3, 0);
    send(3, 108);
    send(3, 109);
    send(3, 0);
    send(3, 0);
    learn_thr = 1'b1;
    for (int k = 0; k < 30; k++) send(3, 255);
    learn_thr = 1'b0;
    send(3, 0);
    send(3, 0);
    send(3, 239);
    send(3, 240);
    send(3, 0);
    send(3, 0);
    learn_thr = 1'b1;
    for (int k = 0; k < 80; k++) send(3, 0);
    learn_thr = 1'b0;
    send(3, int'(mthr[3]) - 1);
    send(3, int'(mthr[3]));
    drain();

    // Interleaved neurons, half leak
    beta = 8'd128;
    for (int r = 0; r < 3; r++) begin
      send(0, 10);
      send(1, 20);
      send(2, 30);
    end
    drain();

    // Output stall: held result, no acceptance, then release
    out_ready = 1'b0;
    send(4, 50);
    in_valid   = 1'b1;
    in_idx     = 4'd5;
    in_current = 8'd77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_idx", out_idx, sb[0].idx);
      chk("stall_out_spike", out_spike, sb[0].spike);
      chk("stall_out_state", out_state, sb[0].state);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    cycle();
    chk("release_accept", last_acc, 1);
    in_valid = 1'b0;
    send(4, 0);
    send(5, 0);
    drain();

    // Reset while a result is stalled
    out_ready = 1'b0;
    send(3, 99);
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_state", out_state, 0);
    sb.delete();
    model_reset();
    out_ready = 1'b1;
    beta = 8'd0;
    send(3, 99);
    send(3, 100);
    beta = 8'd255;
    send(0, 50);
    send(0, 0);
    drain();

    // Second instance: N=12, THR_INIT=250, beta=255, saturation and bad index
    bstep(5, 200, 1, 5, 0, 200);
    bstep(5, 200, 1, 5, 1, 255);
    bstep(13, 100, 0, 0, 0, 0);
    bstep(5, 10, 1, 5, 0, 0);
    bstep(11, 250, 1, 11, 1, 250);
    bstep(10, 249, 1, 10, 0, 249);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
